uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised next-generation UART transmitter: configurable data width, baud divider, parity and stop bits.
//  Has an internal word FIFO with a valid/ready write port, so frames are sent back-to-back with no gap.
//  Sits between the bus/host write path and the serial pin; idles high.
// PARAMETERS
//  DATA_W        8   data bits per frame, legal 5..9, sent LSB first
//  CLKS_PER_BIT  16  clk cycles per serial bit, legal >= 2
//  PARITY        0   0 = none, 1 = even, 2 = odd
//  STOP_BITS     1   stop bits per frame, legal 1 or 2
//  FIFO_DEPTH    4   input FIFO words, power of two, legal >= 2
// PORTS
//  clk        in   1                      single system clock; all state is on its rising edge
//  rst        in   1                      asynchronous, active-low reset (asserted at rst == 0)
//  tx_valid   in   1                      write request
//  tx_data    in   DATA_W                 word to send; sampled when tx_valid && tx_ready
//  tx_ready   out  1                      FIFO not full
//  tx         out  1                      serial output, registered
//  tx_busy    out  1                      FSM not IDLE, or FIFO not empty
//  fifo_count out  $clog2(FIFO_DEPTH)+1   words held in the FIFO
// BEHAVIOUR
//  Reset (asynchronous, immediate):
//   - tx = 1, tx_busy = 0, tx_ready = 1, fifo_count = 0.
//   - FSM -> IDLE; FIFO flushed; baud counter and bit counter cleared.
//   - Reset mid-frame aborts the frame; tx returns high at once.
//  Frame: start(0), DATA_W data bits LSB first, optional parity, STOP_BITS ones.
//   - Every bit holds exactly CLKS_PER_BIT cycles.
//   - Frame length = (1 + DATA_W + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
//  Parity is computed over the word when it is popped:
//   - even: parity bit = ^data.
//   - odd:  parity bit = ~^data.
//  FSM states: IDLE, START, DATA, PAR, STOP.
//   - IDLE:  if FIFO non-empty, pop a word, load the shift register and go to START.
//            tx = 0 from that edge, so the start bit begins 1 cycle after the word is accepted.
//   - START: -> DATA after CLKS_PER_BIT cycles.
//   - DATA:  shift right once per bit; after DATA_W bits go to PAR (PARITY != 0) or STOP.
//   - PAR:   -> STOP after one bit time.
//   - STOP:  after STOP_BITS bit times, if the FIFO is non-empty, pop and go straight to START
//            (no idle cycle between frames); otherwise go to IDLE with tx = 1.
//  Baud counter:
//   - Counts 0..CLKS_PER_BIT-1 and wraps; width $clog2(CLKS_PER_BIT).
//   - Cleared on every state entry.
//  FIFO:
//   - A push occurs when tx_valid && tx_ready.
//   - tx_valid while full is ignored: no push, and fifo_count stays at FIFO_DEPTH.
//   - Push and pop on the same edge leave fifo_count unchanged. This includes the full case,
//     where the pop frees a slot only for the next cycle.
//   - Read and write pointers wrap modulo FIFO_DEPTH.
//   - tx_data changes while tx_valid is low are don't-care.
//  tx_busy is registered, and combinational in no path from tx_valid.
//  tx_ready = (fifo_count != FIFO_DEPTH).
// STRUCTURE
//  Shared package uart_pkg:
//   - parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}.
//   - tx_state_e {IDLE, START, DATA, PAR, STOP}.
//   - Function frame_bits(DATA_W, PARITY, STOP_BITS).
//  Sub-module uart_tx_fifo:
//   - Synchronous FIFO, parameters WIDTH and DEPTH.
//   - Ports push/pop/wdata/rdata/full/empty/count; same clk/rst.
//  Top level: FSM, baud counter, bit counter, shift register, parity bit; elaboration-time
//  parameter-range checks.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
//  1. PARITY=even, STOP_BITS=1, push 8'hA5:
//     tx = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1 (stop); each bit 4 cycles, 44 cycles total.
//     tx_busy drops the cycle after the stop bit ends.
//  2. PARITY=odd, STOP_BITS=2, push 8'h00:
//     parity bit = 1; two stop bits give 48 cycles; tx high afterwards.
//  3. Push 5 words back-to-back while idle:
//     tx_ready falls once 4 words are held; the 5th is accepted after the first pop.
//     All 5 frames are sent with zero idle cycles between stop and start.
//  4. Assert rst low during the DATA bit 3 of a frame:
//     tx = 1, tx_busy = 0 and fifo_count = 0 immediately.
//     After release, a new push of 8'h3C transmits cleanly.
//  5. FIFO full with a pop on the same edge and tx_valid high:
//     no push occurs; fifo_count goes from 4 to 3; the next cycle's push is accepted.
//  6. PARITY=none, DATA_W=5, CLKS_PER_BIT=2, push 5'h15:
//     tx = 0,1,0,1,0,1,1; 14 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;

  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO; rdata shows the head word whenever not empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with input word FIFO; frames leave back-to-back while words are queued.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int      BW    = $clog2(CLKS_PER_BIT);
  localparam int      BITW  = 4;
  localparam int      CW    = $clog2(FIFO_DEPTH) + 1;
  localparam parity_e PMODE = parity_e'(PARITY);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [BITW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic              push, pop, load, bit_end;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CW-1:0]     cnt_nxt;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;

  uart_tx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // tx_d is the line level for the cycle after the edge, so tx stays a pure flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
    bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = shreg_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == BITW'(DATA_W - 1)) begin
          bit_d = '0;
          if (PMODE != PAR_NONE) begin
            state_d = PAR;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          tx_d    = shreg_q[1];
        end
      end
      PAR: if (bit_end) begin
        state_d = STOP;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_q == BITW'(STOP_BITS - 1)) begin
          if (!fifo_empty) load = 1'b1;
          else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      shreg_d = fifo_rdata;
      par_d   = (PMODE == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      state_d = START;
      baud_d  = '0;
      tx_d    = 1'b0;
    end

    cnt_nxt = fifo_count + CW'(push) - CW'(pop);
    busy_d  = (state_d != IDLE) || (cnt_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Three transmitter configurations; tx is recorded once per cycle and compared with frames built from UART rules.
module tb_uart_tx_param;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [4:0] d2 = '0;
  logic       r0, r1, r2, t0, t1, t2, b0, b1, b2;
  logic [2:0] c0, c1, c2;

  // 0: 8 bits, even, 1 stop, 4 clk/bit; 1: 8 bits, odd, 2 stop; 2: 5 bits, none, 2 clk/bit
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(d0), .tx_ready(r0), .tx(t0), .tx_busy(b0), .fifo_count(c0));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1), .tx_ready(r1), .tx(t1), .tx_busy(b1), .fifo_count(c1));
  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .tx_valid(v2), .tx_data(d2), .tx_ready(r2), .tx(t2), .tx_busy(b2), .fifo_count(c2));

  int cfg_dw  [3] = '{8, 8, 5};
  int cfg_cpb [3] = '{4, 4, 2};
  int cfg_par [3] = '{1, 2, 0};
  int cfg_sb  [3] = '{1, 2, 1};

  int checks = 0;
  int errors = 0;

  // Sample k holds the line level just after the k-th rising edge.
  logic wv [3][0:8191];
  logic wb [0:8191];
  int   ncyc = 0;
  always @(posedge clk) begin
    #2;
    if (ncyc < 8192) begin
      wv[0][ncyc] = t0;
      wv[1][ncyc] = t1;
      wv[2][ncyc] = t2;
      wb[ncyc]    = b0;
    end
    ncyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  function automatic logic get_tx(input int sel, input int i);
    if (i < 0 || i >= 8192) return 1'bx;
    return wv[sel][i];
  endfunction

  function automatic int flen(input int sel);
    return frame_bits(cfg_dw[sel], cfg_par[sel], cfg_sb[sel]) * cfg_cpb[sel];
  endfunction

  // Level of frame bit b for word w: start, data LSB first, parity from a ones count, stop.
  function automatic logic exp_bit(input int sel, input logic [8:0] w, input int b);
    int ones = 0;
    int dw   = cfg_dw[sel];
    if (b == 0) return 1'b0;
    if (b <= dw) return w[b-1];
    if (cfg_par[sel] != 0 && b == dw + 1) begin
      for (int k = 0; k < dw; k++) ones += int'(w[k]);
      return (cfg_par[sel] == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  function automatic int first_bad(input int sel, input int s, input logic [8:0] w);
    int cpb = cfg_cpb[sel];
    int nb  = frame_bits(cfg_dw[sel], cfg_par[sel], cfg_sb[sel]);
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < cpb; c++)
        if (get_tx(sel, s + b*cpb + c) !== exp_bit(sel, w, b)) return s + b*cpb + c;
    return -1;
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return r0;
      1:       return r1;
      default: return r2;
    endcase
  endfunction

  // Call at a falling edge; acc is the sample index just after the accepting edge.
  task automatic push(input int sel, input logic [8:0] w, output int acc);
    int n = 0;
    case (sel)
      0:       begin v0 = 1'b1; d0 = w[7:0]; end
      1:       begin v1 = 1'b1; d1 = w[7:0]; end
      default: begin v2 = 1'b1; d2 = w[4:0]; end
    endcase
    while (rdy(sel) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL push_timeout dut%0d: tx_ready %b, expected 1 within 400 cycles", sel, rdy(sel));
    end
    acc = ncyc;
    @(negedge clk);
    case (sel)
      0:       begin v0 = 1'b0; d0 = 8'($urandom); end
      1:       begin v1 = 1'b0; d1 = 8'($urandom); end
      default: begin v2 = 1'b0; d2 = 5'($urandom); end
    endcase
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (t0 !== 1'b1) begin errors++; $display("FAIL reset_tx0: got %b want 1", t0); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", b0); end
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b want 1", r0); end
    checks++; if (c0 !== 3'd0) begin errors++; $display("FAIL reset_count0: got %0d want 0", c0); end
    checks++; if ({t1, t2} !== 2'b11) begin errors++; $display("FAIL reset_tx12: got %b%b want 11", t1, t2); end
    checks++; if ({b1, b2, c1, c2} !== 8'd0) begin errors++; $display("FAIL reset_busy_count12: got %b %b %0d %0d want 0 0 0 0", b1, b2, c1, c2); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_even_a5();
    int acc, bad, l;
    l = flen(0);
    push(0, 9'h0A5, acc);
    repeat (l + 3) @(negedge clk);
    bad = first_bad(0, acc + 1, 9'h0A5);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL even_a5_frame: sample %0d got %b want %b", bad, get_tx(0, bad), exp_bit(0, 9'h0A5, (bad - acc - 1) / 4)); end
    checks++; if (get_tx(0, acc + l + 1) !== 1'b1) begin errors++; $display("FAIL even_a5_idle: tx after frame %b want 1", get_tx(0, acc + l + 1)); end
    checks++; if (wb[acc] !== 1'b1 || wb[acc + l] !== 1'b1) begin errors++; $display("FAIL even_a5_busy_hold: busy %b/%b want 1/1", wb[acc], wb[acc + l]); end
    checks++; if (wb[acc + l + 1] !== 1'b0) begin errors++; $display("FAIL even_a5_busy_drop: busy %b want 0", wb[acc + l + 1]); end
  endtask

  task automatic test_odd_stop2();
    int acc, bad, l;
    l = flen(1);
    push(1, 9'h000, acc);
    repeat (l + 3) @(negedge clk);
    bad = first_bad(1, acc + 1, 9'h000);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL odd_stop2_frame: sample %0d got %b want %b", bad, get_tx(1, bad), exp_bit(1, 9'h000, (bad - acc - 1) / 4)); end
    checks++; if (get_tx(1, acc + l + 1) !== 1'b1 || t1 !== 1'b1) begin errors++; $display("FAIL odd_stop2_idle: tx %b/%b want 1/1", get_tx(1, acc + l + 1), t1); end
  endtask

  task automatic test_dw5_none();
    int acc, bad, l;
    l = flen(2);
    push(2, 9'h015, acc);
    repeat (l + 3) @(negedge clk);
    bad = first_bad(2, acc + 1, 9'h015);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL dw5_frame: sample %0d got %b want %b", bad, get_tx(2, bad), exp_bit(2, 9'h015, (bad - acc - 1) / 2)); end
    checks++; if (get_tx(2, acc + l + 1) !== 1'b1 || b2 !== 1'b0) begin errors++; $display("FAIL dw5_idle: tx %b busy %b want 1 0", get_tx(2, acc + l + 1), b2); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] w [5];
    int acc, acc0, bad, l;
    l = flen(0);
    for (int k = 0; k < 5; k++) begin
      w[k] = 9'($urandom_range(0, 255));
      push(0, w[k], acc);
      if (k == 0) acc0 = acc;
    end
    // first pop lands the edge after the first push, so five pushes leave four held
    checks++; if (c0 !== 3'd4 || r0 !== 1'b0) begin errors++; $display("FAIL b2b_full: count %0d ready %b want 4 0", c0, r0); end
    while (ncyc <= acc0 + 5*l + 3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      bad = first_bad(0, acc0 + 1 + k*l, w[k]);
      checks++;
      if (bad != -1) begin errors++; $display("FAIL b2b_frame%0d: sample %0d got %b want %b", k, bad, get_tx(0, bad), exp_bit(0, w[k], (bad - acc0 - 1 - k*l) / 4)); end
    end
    checks++; if (get_tx(0, acc0 + 5*l + 1) !== 1'b1 || b0 !== 1'b0) begin errors++; $display("FAIL b2b_end: tx %b busy %b want 1 0", get_tx(0, acc0 + 5*l + 1), b0); end
  endtask

  task automatic test_full_pop();
    logic [8:0] w [6];
    int acc, acc0, bad, l, n;
    l = flen(0);
    for (int k = 0; k < 5; k++) begin
      w[k] = 9'($urandom_range(0, 255));
      push(0, w[k], acc);
      if (k == 0) acc0 = acc;
    end
    w[5] = 9'($urandom_range(0, 255));
    v0 = 1'b1;
    d0 = w[5][7:0];
    n = 0;
    while (c0 === 3'd4 && n < 2*l) begin
      @(negedge clk);
      n++;
    end
    checks++; if (c0 !== 3'd3 || r0 !== 1'b1) begin errors++; $display("FAIL full_pop_drop: count %0d ready %b want 3 1", c0, r0); end
    @(negedge clk);
    checks++; if (c0 !== 3'd4) begin errors++; $display("FAIL full_pop_next_push: count %0d want 4", c0); end
    v0 = 1'b0;
    while (ncyc <= acc0 + 6*l + 3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      bad = first_bad(0, acc0 + 1 + k*l, w[k]);
      checks++;
      if (bad != -1) begin errors++; $display("FAIL full_pop_frame%0d: sample %0d got %b want %b", k, bad, get_tx(0, bad), exp_bit(0, w[k], (bad - acc0 - 1 - k*l) / 4)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] w0;
    int acc, acc1, bad, l;
    l = flen(0);
    w0 = 9'($urandom_range(0, 255)) & 9'h0F7;
    push(0, w0, acc);
    push(0, 9'($urandom_range(0, 255)), acc1);
    // data bit 3 occupies samples acc+17 .. acc+20
    while (ncyc <= acc + 18) @(negedge clk);
    checks++; if (t0 !== 1'b0 || c0 !== 3'd1) begin errors++; $display("FAIL rst_mid_pre: tx %b count %0d want 0 1", t0, c0); end
    #1 rst = 1'b0;
    #1;
    checks++; if (t0 !== 1'b1 || b0 !== 1'b0) begin errors++; $display("FAIL rst_mid_out: tx %b busy %b want 1 0", t0, b0); end
    checks++; if (c0 !== 3'd0 || r0 !== 1'b1) begin errors++; $display("FAIL rst_mid_fifo: count %0d ready %b want 0 1", c0, r0); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(0, 9'h03C, acc);
    repeat (l + 3) @(negedge clk);
    bad = first_bad(0, acc + 1, 9'h03C);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL rst_mid_3c: sample %0d got %b want %b", bad, get_tx(0, bad), exp_bit(0, 9'h03C, (bad - acc - 1) / 4)); end
  endtask

  task automatic test_random();
    logic [8:0] q [$];
    logic [8:0] w;
    int acc, bad, l, st, i, nf, n;
    l  = flen(0);
    st = ncyc;
    for (int k = 0; k < 20; k++) begin
      w = 9'($urandom_range(0, 255));
      q.push_back(w);
      push(0, w, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    n = 0;
    while (b0 !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL rand_drain: busy %b want 0", b0); end
    repeat (2) @(negedge clk);
    // receiver model: find each start bit and compare the full frame against the queue
    i  = st;
    nf = 0;
    while (i < ncyc - 1) begin
      if (get_tx(0, i) === 1'b0) begin
        checks++;
        if (nf >= q.size()) begin
          errors++; $display("FAIL rand_extra_frame: frame %0d at sample %0d, want %0d frames", nf, i, q.size());
        end else begin
          bad = first_bad(0, i, q[nf]);
          if (bad != -1) begin errors++; $display("FAIL rand_frame%0d: sample %0d got %b want %b", nf, bad, get_tx(0, bad), exp_bit(0, q[nf], (bad - i) / 4)); end
        end
        nf++;
        i += l;
      end else begin
        i++;
      end
    end
    checks++; if (nf != q.size()) begin errors++; $display("FAIL rand_frame_count: got %0d want %0d", nf, q.size()); end
  endtask

  initial begin
    test_reset();
    test_even_a5();
    test_odd_stop2();
    test_dw5_none();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
